// File: rtl/stage_control.sv
// Game stage sequencer: three stages separated by frame-counted pauses,
// ending in WIN or LOSE until the player presses start again.
module stage_control #(
  parameter int unsigned INTERMISSION_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       stage_1_car_done,
  input  logic       stage_2_car_done,
  input  logic       stage_3_car_done,
  input  logic       game_over_feedback,
  output logic       stage_1_in_progress,
  output logic       stage_2_in_progress,
  output logic       stage_3_in_progress,
  output logic       stage_start,
  output logic [1:0] current_stage,
  output logic       game_won,
  output logic       game_lost
);

  typedef enum logic [2:0] {
    IDLE, STAGE1, PAUSE1, STAGE2, PAUSE2, STAGE3, WIN, LOSE
  } state_t;

  localparam logic [7:0] PAUSE_LAST = 8'(INTERMISSION_FRAMES - 1);

  state_t     state, state_nxt;
  logic       start_q, armed;
  logic [7:0] pause_cnt;
  logic       start_rise, cur_done, in_stage, in_pause;
  logic       nxt_stage, nxt_pause, changing, pause_last;

  assign start_rise = start & ~start_q;
  assign in_stage   = (state == STAGE1) || (state == STAGE2) || (state == STAGE3);
  assign in_pause   = (state == PAUSE1) || (state == PAUSE2);
  assign nxt_stage  = (state_nxt == STAGE1) || (state_nxt == STAGE2) || (state_nxt == STAGE3);
  assign nxt_pause  = (state_nxt == PAUSE1) || (state_nxt == PAUSE2);
  assign changing   = (state_nxt != state);
  assign pause_last = frame_tick && (pause_cnt == PAUSE_LAST);

  // Only the active stage's done input matters.
  always_comb begin
    cur_done = 1'b0;
    case (state)
      STAGE1:  cur_done = stage_1_car_done;
      STAGE2:  cur_done = stage_2_car_done;
      STAGE3:  cur_done = stage_3_car_done;
      default: cur_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start_rise) state_nxt = STAGE1;
      STAGE1: if (game_over_feedback) state_nxt = LOSE;
              else if (armed && cur_done) state_nxt = PAUSE1;
      STAGE2: if (game_over_feedback) state_nxt = LOSE;
              else if (armed && cur_done) state_nxt = PAUSE2;
      STAGE3: if (game_over_feedback) state_nxt = LOSE;
              else if (armed && cur_done) state_nxt = WIN;
      PAUSE1: if (pause_last) state_nxt = STAGE2;
      PAUSE2: if (pause_last) state_nxt = STAGE3;
      WIN,
      LOSE:   if (start_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Armed blocks a done level left over from the previous stage until it drops.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q     <= 1'b0;
      armed       <= 1'b0;
      stage_start <= 1'b0;
      pause_cnt   <= 8'd0;
    end else begin
      start_q     <= start;
      stage_start <= nxt_stage && changing;
      if (nxt_stage && changing)    armed <= 1'b0;
      else if (in_stage && !cur_done) armed <= 1'b1;
      if (nxt_pause && changing)    pause_cnt <= 8'd0;
      else if (in_pause && frame_tick && pause_cnt != 8'hFF) pause_cnt <= pause_cnt + 8'd1;
    end
  end

  always_comb begin
    stage_1_in_progress = 1'b0;
    stage_2_in_progress = 1'b0;
    stage_3_in_progress = 1'b0;
    current_stage       = 2'd0;
    game_won            = 1'b0;
    game_lost           = 1'b0;
    case (state)
      STAGE1: begin stage_1_in_progress = 1'b1; current_stage = 2'd1; end
      STAGE2: begin stage_2_in_progress = 1'b1; current_stage = 2'd2; end
      STAGE3: begin stage_3_in_progress = 1'b1; current_stage = 2'd3; end
      WIN:    game_won  = 1'b1;
      LOSE:   game_lost = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_stage_control.sv
// Randomized + directed bench for stage_control with a queue-based scoreboard.
module tb_stage_control;
  localparam int IF_N = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0, frame_tick = 1'b0, game_over_feedback = 1'b0;
  logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic s1, s2, s3, stage_start, game_won, game_lost;
  logic [1:0] current_stage;

  int checks = 0, passes = 0;
  bit started = 0;
  logic [7:0] exp_q[$];

  stage_control #(.INTERMISSION_FRAMES(IF_N)) dut (
    .clk(clk), .resetn(resetn), .start(start), .frame_tick(frame_tick),
    .stage_1_car_done(d1), .stage_2_car_done(d2), .stage_3_car_done(d3),
    .game_over_feedback(game_over_feedback),
    .stage_1_in_progress(s1), .stage_2_in_progress(s2), .stage_3_in_progress(s3),
    .stage_start(stage_start), .current_stage(current_stage),
    .game_won(game_won), .game_lost(game_lost)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dut_vec();
    return {s1, s2, s3, stage_start, current_stage, game_won, game_lost};
  endfunction

  // Reference model: active stage number, pending pause target with a frame
  // countdown, terminal flags, and whether a done-low has been seen this stage.
  int m_stage, m_pause_to, m_frames;
  bit m_won, m_lost, m_armed, m_first, m_prev_start;

  function automatic void m_reset();
    m_stage = 0; m_pause_to = 0; m_frames = 0;
    m_won = 0; m_lost = 0; m_armed = 0; m_first = 0; m_prev_start = 0;
  endfunction

  function automatic void m_enter(input int n);
    m_stage = n; m_armed = 0; m_first = 1;
  endfunction

  function automatic logic [7:0] m_vec();
    logic [1:0] cs;
    cs = 2'(m_stage);
    return {m_stage == 1, m_stage == 2, m_stage == 3, m_first, cs, m_won, m_lost};
  endfunction

  initial m_reset();

  always @(negedge resetn) begin
    m_reset();
    exp_q.delete();
    if (started) exp_q.push_back(8'h00);
  end

  always @(posedge clk) begin
    bit rise, done;
    started = 1;
    if (!resetn) begin
      m_reset();
    end else begin
      rise = start && !m_prev_start;
      m_prev_start = start;
      m_first = 0;
      if (m_won || m_lost) begin
        if (rise) begin m_won = 0; m_lost = 0; end
      end else if (m_stage != 0) begin
        done = (m_stage == 1) ? d1 : (m_stage == 2) ? d2 : d3;
        if (game_over_feedback) begin
          m_lost = 1; m_stage = 0;
        end else if (m_armed && done) begin
          if (m_stage == 3) m_won = 1;
          else begin m_pause_to = m_stage + 1; m_frames = IF_N; end
          m_stage = 0;
        end else if (!done) m_armed = 1;
      end else if (m_pause_to != 0) begin
        if (frame_tick) begin
          m_frames--;
          if (m_frames == 0) begin m_enter(m_pause_to); m_pause_to = 0; end
        end
      end else if (rise) m_enter(1);
    end
    exp_q.push_back(m_vec());
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (started) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL scoreboard_empty: no expected entry at %0t", $time);
      else begin
        e = exp_q.pop_front();
        if (dut_vec() === e) passes++;
        else $display("FAIL outputs at %0t: got %b required %b (s1 s2 s3 start cs won lost)",
                      $time, dut_vec(), e);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    hold(3);
    resetn = 1; hold(2);
    // Stage 1 with a done low-then-high, pause, stage 2 entered with stale done.
    start = 1; hold(1); start = 0; hold(2);
    d1 = 1; hold(2); d2 = 1;
    frame_tick = 1; hold(2); frame_tick = 0; hold(10);
    d2 = 0; hold(1); d2 = 1; hold(2);
    frame_tick = 1; hold(2); frame_tick = 0; hold(2);
    // Game over and done together: loss wins.
    game_over_feedback = 1; d3 = 1; hold(1);
    game_over_feedback = 0; d3 = 0; hold(3);
    start = 1; hold(1); start = 0; hold(2);
    // Full game to WIN, start held high afterwards.
    start = 1; hold(1); start = 0; hold(2);
    d1 = 0; hold(1); d1 = 1; hold(1);
    frame_tick = 1; hold(2); frame_tick = 0; hold(1);
    d2 = 0; hold(1); d2 = 1; hold(1);
    frame_tick = 1; hold(2); frame_tick = 0; hold(2);
    d3 = 1; start = 1; hold(1000);
    start = 0; hold(2); start = 1; hold(1); start = 0;
    d1 = 0; d2 = 0; d3 = 0; hold(2);
    // Asynchronous reset in the middle of pause 1.
    start = 1; hold(1); start = 0; hold(2);
    d1 = 1; hold(1); frame_tick = 1; hold(1); frame_tick = 0;
    #2 resetn = 0;
    #1 checks++;
    if (dut_vec() === 8'h00) passes++;
    else $display("FAIL async_reset: got %b required 00000000", dut_vec());
    @(posedge clk); #1 resetn = 1; d1 = 0;
    frame_tick = 1; hold(3); frame_tick = 0; hold(2);
    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) start = ~start;
      if ($urandom_range(0, 5) == 0) d1 = ~d1;
      if ($urandom_range(0, 5) == 0) d2 = ~d2;
      if ($urandom_range(0, 5) == 0) d3 = ~d3;
      game_over_feedback = ($urandom_range(0, 59) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      resetn = ($urandom_range(0, 799) != 0);
      hold(1);
    end
    resetn = 1; hold(2);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
